// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file and its bus interface.
package regfile_sb_pkg;

    localparam int unsigned DEF_XLEN   = 32;
    localparam int unsigned DEF_NREG   = 32;
    localparam int unsigned DEF_NREAD  = 2;
    localparam int unsigned DEF_NWRITE = 2;
    localparam int unsigned DEF_TAGW   = 4;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the scoreboarded register file.
// Ports are flattened vectors so NREAD and NWRITE stay arbitrary.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned NREG   = DEF_NREG,
    parameter int unsigned NREAD  = DEF_NREAD,
    parameter int unsigned NWRITE = DEF_NWRITE,
    parameter int unsigned TAGW   = DEF_TAGW
);
    localparam int unsigned AW = $clog2(NREG);

    // read ports
    logic [NREAD*AW-1:0]     rs_addr;
    logic [NREAD-1:0]        rs_valid;
    logic [NREAD*XLEN-1:0]   rs_data;
    logic [NREAD*TAGW-1:0]   rs_tag;
    // reservation from decode
    logic                    reserve;
    logic [AW-1:0]           rd;
    logic [TAGW-1:0]         rd_tag;
    // writeback ports
    logic [NWRITE-1:0]       wen;
    logic [NWRITE*AW-1:0]    wreg;
    logic [NWRITE*TAGW-1:0]  wtag;
    logic [NWRITE*XLEN-1:0]  wdata;
    // control / status
    logic                    flush;
    logic [AW:0]             pend_cnt;

    modport master (
        output rs_addr, reserve, rd, rd_tag, wen, wreg, wtag, wdata, flush,
        input  rs_valid, rs_data, rs_tag, pend_cnt
    );

    modport slave (
        input  rs_addr, reserve, rd, rd_tag, wen, wreg, wtag, wdata, flush,
        output rs_valid, rs_data, rs_tag, pend_cnt
    );

endinterface : regfile_sb_if

// File: rtl/regfile_sb_bypass.sv
// One read port: x0 forcing, same-cycle writeback bypass, stored-state fallback.
module regfile_sb_bypass #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NWRITE = 2,
    parameter int unsigned TAGW   = 4
) (
    input  logic [AW-1:0]          addr,
    input  logic                   st_valid,
    input  logic [XLEN-1:0]        st_data,
    input  logic [TAGW-1:0]        st_owner,
    input  logic [NWRITE-1:0]      commit,
    input  logic [NWRITE*AW-1:0]   wreg,
    input  logic [NWRITE*XLEN-1:0] wdata,
    output logic                   valid_c,
    output logic [XLEN-1:0]        data_c,
    output logic [TAGW-1:0]        tag_c
);

    // Later write ports override earlier ones, so the highest committing index wins.
    always_comb begin
        valid_c = st_valid;
        data_c  = st_data;
        tag_c   = st_valid ? '0 : st_owner;
        for (int j = 0; j < int'(NWRITE); j++) begin
            if (commit[j] && (wreg[j*AW +: AW] == addr)) begin
                valid_c = 1'b1;
                data_c  = wdata[j*XLEN +: XLEN];
                tag_c   = '0;
            end
        end
        if (addr == '0) begin
            valid_c = 1'b1;
            data_c  = '0;
            tag_c   = '0;
        end
    end

endmodule : regfile_sb_bypass

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register producer-tag scoreboard.
// Stale writebacks (tag mismatch or register already valid) are dropped.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned NREG   = DEF_NREG,
    parameter int unsigned NREAD  = DEF_NREAD,
    parameter int unsigned NWRITE = DEF_NWRITE,
    parameter int unsigned TAGW   = DEF_TAGW
) (
    input  logic          clk,
    input  logic          reset,
    regfile_sb_if.slave   bus
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]   data_q  [NREG];
    logic [XLEN-1:0]   data_n  [NREG];
    logic [TAGW-1:0]   owner_q [NREG];
    logic [TAGW-1:0]   owner_n [NREG];
    logic [NREG-1:0]   valid_q;
    logic [NREG-1:0]   valid_n;
    logic [CW-1:0]     pend_q;
    logic [CW-1:0]     pend_n;
    logic [NWRITE-1:0] commit_c;

    logic [NREAD-1:0]      rs_valid_c;
    logic [NREAD*XLEN-1:0] rs_data_c;
    logic [NREAD*TAGW-1:0] rs_tag_c;

    // A write commits only into a pending register whose newest producer it is.
    always_comb begin
        commit_c = '0;
        for (int j = 0; j < int'(NWRITE); j++) begin
            commit_c[j] = bus.wen[j]
                       && (bus.wreg[j*AW +: AW] != '0)
                       && !valid_q[bus.wreg[j*AW +: AW]]
                       && (bus.wtag[j*TAGW +: TAGW] == owner_q[bus.wreg[j*AW +: AW]]);
        end
    end

    // Next state: commits, then flush or reserve (reserve overrides a same-cycle commit's valid).
    always_comb begin
        data_n  = data_q;
        owner_n = owner_q;
        valid_n = valid_q;
        for (int j = 0; j < int'(NWRITE); j++) begin
            if (commit_c[j]) begin
                data_n[bus.wreg[j*AW +: AW]]  = bus.wdata[j*XLEN +: XLEN];
                valid_n[bus.wreg[j*AW +: AW]] = 1'b1;
            end
        end
        if (bus.flush) begin
            valid_n = '1;
        end else if (bus.reserve && (bus.rd != '0)) begin
            valid_n[bus.rd] = 1'b0;
            owner_n[bus.rd] = bus.rd_tag;
        end
        valid_n[0] = 1'b1;
        data_n[0]  = '0;
        owner_n[0] = '0;
    end

    // Pending count from next-state so the registered value tracks valid exactly.
    always_comb begin
        pend_n = '0;
        for (int r = 1; r < int'(NREG); r++) begin
            pend_n = pend_n + CW'(!valid_n[r]);
        end
    end

    // State registers; synchronous reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < int'(NREG); r++) begin
                data_q[r]  <= '0;
                owner_q[r] <= '0;
            end
            valid_q <= '1;
            pend_q  <= '0;
        end else begin
            data_q  <= data_n;
            owner_q <= owner_n;
            valid_q <= valid_n;
            pend_q  <= pend_n;
        end
    end

    // One bypass mux per read port.
    for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = bus.rs_addr[i*AW +: AW];

        regfile_sb_bypass #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWRITE (NWRITE),
            .TAGW   (TAGW)
        ) u_bypass (
            .addr     (addr),
            .st_valid (valid_q[addr]),
            .st_data  (data_q[addr]),
            .st_owner (owner_q[addr]),
            .commit   (commit_c),
            .wreg     (bus.wreg),
            .wdata    (bus.wdata),
            .valid_c  (rs_valid_c[i]),
            .data_c   (rs_data_c[i*XLEN +: XLEN]),
            .tag_c    (rs_tag_c[i*TAGW +: TAGW])
        );
    end

    assign bus.rs_valid = rs_valid_c;
    assign bus.rs_data  = rs_data_c;
    assign bus.rs_tag   = rs_tag_c;
    assign bus.pend_cnt = pend_q;

endmodule : regfile_sb

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port integer register file with a tag-based scoreboard.
- Successor to the single-write-port valid-bit regfile:
  - configurable XLEN, register count, read-port count and write-port count;
  - each pending register records the tag of its newest producer, so stale out-of-order writebacks are discarded (WAW-safe);
  - global flush;
  - live count of pending registers.
- Sits between decode (read/reserve) and the writeback ports of the execute units.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural registers; x0 hardwired zero; power of two, at least 2.
- NREAD, 2, read ports.
- NWRITE, 2, write ports.
- TAGW, 4, producer tag width.
- AW (localparam), $clog2(NREG), register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_addr  in  NREAD*AW  read addresses; port i = bits [i*AW +: AW].
- rs_valid  out  NREAD  operand available on port i.
- rs_data  out  NREAD*XLEN  operand data.
- rs_tag  out  NREAD*TAGW  owner tag of the register when rs_valid=0; 0 otherwise.
- reserve  in  1  mark rd pending.
- rd  in  AW  register to reserve.
- rd_tag  in  TAGW  producer tag recorded for rd.
- wen  in  NWRITE  write enables.
- wreg  in  NWRITE*AW  write addresses.
- wtag  in  NWRITE*TAGW  producer tag of each write.
- wdata  in  NWRITE*XLEN  write data.
- flush  in  1  squash all pending reservations.
- pend_cnt  out  AW+1  number of registers currently pending (registered).

Behaviour:
- State per register r (1..NREG-1): data[r] (XLEN), valid[r], owner[r] (TAGW).
- Reset (reset=1 at edge): all data=0, valid=1, owner=0, pend_cnt=0.
  - Reset overrides every other input in the same cycle, including a reset asserted mid-reservation.
  - After reset, every read returns valid=1, data=0, tag=0.
- Write j commits when all hold:
  - wen[j]=1, wreg[j]!=0, valid[wreg[j]]=0, wtag[j]==owner[wreg[j]].
  - On commit: data<=wdata[j], valid<=1.
  - Non-matching writes are silently dropped: stale tag, or target already valid.
  - Writes to x0 are always dropped.
- Two committing writes to the same register in one cycle: the higher index j wins. This indicates a tag collision upstream and must not occur in normal operation.
- Reads are combinational, zero latency.
  - addr 0: valid=1, data=0, tag=0.
  - Else, if some write j commits to addr this cycle: valid=1, data=wdata[j] (highest such j). This is the bypass.
  - Else: valid[addr], data[addr], tag = valid ? 0 : owner[addr].
- Reserve (reserve=1, rd!=0): next cycle valid[rd]=0, owner[rd]=rd_tag.
  - Reserve takes precedence over a commit to the same register in the same cycle. The data is still written, but valid ends 0 with the new owner.
  - A reservation is not visible to reads in its own cycle.
  - Re-reserving an already pending register only replaces owner; the old producer's writeback is then dropped.
- Flush=1 (and reset=0):
  - Commits in the same cycle still update data.
  - All valid<=1; reserve is ignored; owner unchanged.
  - Data keeps the last committed value.
- pend_cnt: registered population count of ~valid, recomputed from next-state every cycle. Range 0..NREG-1.

Decomposition:
- No shared package typedefs needed beyond what is already there.
- Optional sub-module regfile_sb_bypass: one read port's mux. Instantiate NREAD times with a generate loop.
- Ports are flattened vectors so NREAD and NWRITE stay arbitrary.

Test Plan:
- Reset: assert reset 2 cycles -> all rs_valid=1, rs_data=0, pend_cnt=0; read x0 always 0/valid.
- Reserve x5 tag 3, read x5 next cycle -> rs_valid=0, rs_tag=3, pend_cnt=1. wen[0] x5 tag 3 data 0xDEADBEEF -> same-cycle rs_data=0xDEADBEEF valid=1; next cycle stored, pend_cnt=0.
- WAW: reserve x7 tag 1, then reserve x7 tag 2. Write x7 tag 1 data 0x11 -> dropped, rs_valid=0, rs_tag=2. Write tag 2 data 0x22 -> valid, data 0x22.
- Dual write port: reserve x3 tag 4 and x9 tag 5. Same cycle wen=2'b11 (x3/4/0xA, x9/5/0xB) -> both read ports bypass correctly; pend_cnt goes 2->0.
- Same-cycle reserve and commit on x4 (owner 6 pending, write tag 6 data 0x44, reserve tag 7) -> next cycle x4 data=0x44, valid=0, tag=7.
- Flush with x2, x8 pending and reserve x10 in the same cycle -> next cycle all valid, pend_cnt=0, x10 not reserved. Reset asserted together with a write -> write ignored, data=0.
